pwm_duty_ctrl: RTL
==================

PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 The module SHALL have parameter NCH, default 4: number of PWM channels.
REQ-002 The module SHALL have parameter NREQ, default 2: number of command requesters (e.g. button debouncer, host).
REQ-003 The module SHALL have parameter PERIOD, default 10: PWM period in clk cycles; counter runs 0..PERIOD-1.
REQ-004 The module SHALL have parameter DUTY_W, default 4: duty width, with 2^DUTY_W > PERIOD.
REQ-005 The module SHALL have parameter DUTY_INIT, default 5: reset duty for every channel (50 %).
REQ-006 The module SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-007 The module SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 The module SHALL have port en  in  1  PWM run enable.
REQ-009 The module SHALL have port req_valid  in  NREQ  per-requester command valid.
REQ-010 The module SHALL have port req_ready  out  NREQ  per-requester command accept.
REQ-011 The module SHALL have port req_chan  in  NREQ*clog2(NCH)  target channel, packed per requester.
REQ-012 The module SHALL have port req_op  in  NREQ*2  opcode: 00 SET, 01 INC, 10 DEC, 11 reserved.
REQ-013 The module SHALL have port req_val  in  NREQ*DUTY_W  SET value.
REQ-014 The module SHALL have port pwm_out  out  NCH  PWM outputs.
REQ-015 The module SHALL have port duty_active  out  NCH*DUTY_W  committed duty per channel.
REQ-016 The module SHALL have port period_start  out  1  high while the counter equals 0 and en=1.
REQ-017 The module SHALL have port cmd_err  out  1  one-cycle pulse when a reserved opcode is accepted.

Function
REQ-018 The module SHALL grant at most one requester per cycle by round-robin; req_ready is combinational from req_valid and the priority pointer.
REQ-019 A command SHALL be accepted when req_valid&req_ready; the pointer then moves to the requester after the granted one.
REQ-020 With no accept, the pointer SHALL hold.
REQ-021 A requester SHALL hold valid and its fields stable until accepted; losing requesters wait and are not dropped.
REQ-022 An accepted command SHALL update the shadow duty of req_chan on the next clock edge (latency 1).
REQ-023 SET SHALL load min(req_val, PERIOD).
REQ-024 INC SHALL add 1, saturating at PERIOD.
REQ-025 DEC SHALL subtract 1, saturating at 0.
REQ-026 A reserved opcode SHALL leave the shadow unchanged and pulse cmd_err for one cycle.
REQ-027 Shadow values SHALL commit to duty_active only on the edge where the counter wraps from PERIOD-1 to 0, so no period is truncated or extended.
REQ-028 A command accepted in the cycle the counter equals PERIOD-1 SHALL be included in that commit.
REQ-029 Repeated commands within one period SHALL accumulate in the shadow; only the final value commits.
REQ-030 pwm_out[i] SHALL be 1 iff en=1 and counter < duty_active[i]: duty 0 gives constant low, duty PERIOD gives constant high.
REQ-031 When en=0 the counter SHALL be held at 0 and pwm_out SHALL be 0.
REQ-032 When en=0 commands SHALL still be accepted, and shadow SHALL copy to active every cycle.
REQ-033 When en rises, the counter SHALL start at 0 on the next edge and period_start SHALL go high.

Reset
REQ-034 Asserting rst SHALL immediately set counter=0, shadow=active=DUTY_INIT for all channels, and the priority pointer to requester 0.
REQ-035 During reset, cmd_err=0, pwm_out=0 and req_ready=0.
REQ-036 A reset asserted mid-period SHALL abort the period and discard any uncommitted shadow values.
REQ-037 After rst falls, the first edge with en=1 SHALL begin a new period at counter 0.

Structure
REQ-038 The opcode constants, PERIOD and DUTY_INIT defaults SHALL live in shared package pwm_pkg.
REQ-039 The round-robin grant logic SHALL be a single sub-module pwm_rr_arb (NREQ requests, grant one-hot, pointer advance on accept).
REQ-040 The counter, shadow/active registers and compare SHALL remain in pwm_duty_ctrl.

Verification
REQ-041 The bench SHALL check: after reset with en=1 and no commands, every pwm_out is high for 5 of 10 cycles and period_start pulses every 10 cycles.
REQ-042 The bench SHALL check: requester 0 sends SET ch1=8 at counter 3, so ch1 stays at 5 high cycles that period and has 8 from the next period_start; a mid-period duty_active change is a failure.
REQ-043 The bench SHALL check: both requesters are valid for INC ch0 on 4 consecutive cycles, so grants alternate 0,1,0,1 and ch0 commits at 9; 6 further INCs leave it saturated at 10 with constant high.
REQ-044 The bench SHALL check: 6 DECs on ch2 from 5 give duty 0 and constant low, and opcode 11 pulses cmd_err once with duty unchanged.
REQ-045 The bench SHALL check: SET ch3=15 clamps to 10, and a command accepted at counter 9 commits at the immediately following wrap.
REQ-046 The bench SHALL check: rst asserted at counter 6 after SET ch0=2 (uncommitted) gives counter 0 and duty 5 at once, with pwm_out low during reset.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared opcodes and default timing for the PWM duty controller.
package pwm_pkg;
   typedef enum logic [1:0] {OP_SET = 2'b00, OP_INC = 2'b01, OP_DEC = 2'b10, OP_RSV = 2'b11} op_e;
   localparam int PERIOD_DEF    = 10;
   localparam int DUTY_INIT_DEF = 5;
endpackage

// File: rtl/pwm_rr_arb.sv
// pwm_rr_arb: round-robin one-hot grant; pointer moves past the winner on every grant.
module pwm_rr_arb #(
   parameter  int N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt
);
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_nxt;
   // Scan from the far end back to the pointer so the closest requester wins last.
   always_comb begin
      o_gnt = '0;
      w_nxt = r_ptr;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[(int'(r_ptr) + k) % N]) begin
            o_gnt = '0;
            o_gnt[(int'(r_ptr) + k) % N] = 1'b1;
            w_nxt = PW'((int'(r_ptr) + k + 1) % N);
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_ptr <= '0;
      else     r_ptr <= w_nxt;
   end
endmodule

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: multi-channel PWM with arbitrated duty commands; shadow duties
// commit to the active set only at the period wrap so no period is distorted.
module pwm_duty_ctrl import pwm_pkg::*; #(
   parameter  int NCH       = 4,
   parameter  int NREQ      = 2,
   parameter  int PERIOD    = PERIOD_DEF,
   parameter  int DUTY_W    = 4,
   parameter  int DUTY_INIT = DUTY_INIT_DEF,
   localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*CHW-1:0]    req_chan,
   input  logic [NREQ*2-1:0]      req_op,
   input  logic [NREQ*DUTY_W-1:0] req_val,
   output logic [NCH-1:0]         pwm_out,
   output logic [NCH*DUTY_W-1:0]  duty_active,
   output logic                   period_start,
   output logic                   cmd_err
);
   localparam logic [DUTY_W-1:0] LP_PER  = DUTY_W'(PERIOD);
   localparam logic [DUTY_W-1:0] LP_LAST = DUTY_W'(PERIOD - 1);
   localparam logic [DUTY_W-1:0] LP_INIT = DUTY_W'(DUTY_INIT);
   logic [DUTY_W-1:0]            r_cnt;
   logic [NCH-1:0][DUTY_W-1:0]   r_shadow;
   logic [NCH-1:0][DUTY_W-1:0]   r_active;
   logic                         r_err;
   logic [NCH-1:0][DUTY_W-1:0]   w_shadow_nxt;
   logic [NREQ-1:0]              w_gnt;
   logic [CHW-1:0]               w_chan;
   op_e                          w_op;
   logic [DUTY_W-1:0]            w_val;
   logic [DUTY_W-1:0]            w_cur;
   logic [DUTY_W-1:0]            w_upd;
   logic                         w_acc;
   logic                         w_load;
   pwm_rr_arb #(.N(NREQ)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .i_req (req_valid),
      .o_gnt (w_gnt)
   );
   assign req_ready = w_gnt & {NREQ{~rst}};
   assign w_acc     = |req_ready;
   always_comb begin
      w_chan = '0;
      w_op   = OP_SET;
      w_val  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_gnt[k]) begin
            w_chan = req_chan[k*CHW +: CHW];
            w_op   = op_e'(req_op[k*2 +: 2]);
            w_val  = req_val[k*DUTY_W +: DUTY_W];
         end
      end
   end
   assign w_cur = r_shadow[w_chan];
   assign w_upd = (w_op == OP_SET) ? ((w_val > LP_PER) ? LP_PER : w_val) :
                  (w_op == OP_INC) ? ((w_cur >= LP_PER) ? LP_PER : w_cur + 1'b1) :
                  (w_op == OP_DEC) ? ((w_cur == '0) ? '0 : w_cur - 1'b1) : w_cur;
   always_comb begin
      w_shadow_nxt = r_shadow;
      if (w_acc && w_op != OP_RSV && int'(w_chan) < NCH) w_shadow_nxt[w_chan] = w_upd;
   end
   // While stopped the active set tracks the shadow so a restart uses fresh duties.
   assign w_load = !en || r_cnt == LP_LAST;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_shadow <= {NCH{LP_INIT}};
         r_active <= {NCH{LP_INIT}};
         r_err    <= 1'b0;
      end else begin
         r_cnt    <= w_load ? '0 : r_cnt + 1'b1;
         r_shadow <= w_shadow_nxt;
         r_err    <= w_acc && w_op == OP_RSV;
         if (w_load) r_active <= w_shadow_nxt;
      end
   end
   always_comb begin
      pwm_out = '0;
      for (int c = 0; c < NCH; c++) pwm_out[c] = en && !rst && (r_cnt < r_active[c]);
   end
   assign duty_active  = r_active;
   assign period_start = en && (r_cnt == '0);
   assign cmd_err      = r_err;
endmodule
